isop_mac_scheduler: RTL and testbench
=====================================

# isop_mac_scheduler

Serial-MAC scheduler for the ISOP compensation FIR that follows the CIC decimator. It replaces the 15-multiplier parallel form with one multiplier time-shared across all taps. It owns the sample history buffer, a runtime-writable coefficient bank, and the accept/compute/emit sequencing. Input rate after decimation is far below clk, so one output per TAPS+1 cycles is sufficient.

## Interface
- TAPS, 15, number of FIR taps (odd, ≤16)
- DW, 8, signed sample width, in and out
- CW, 26, signed coefficient width
- ACCW, 40, signed accumulator width
- SHIFT, 23, output slice LSB (coefficient scale 2^SHIFT)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid&in_ready
- in_data  in  DW  signed sample from CIC
- out_valid  out  1  one-cycle pulse, out_data new
- out_data  out  DW  signed filtered sample, held until next pulse
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  4  tap index
- cfg_data  in  CW  signed coefficient
- cfg_ready  out  1  cfg write taken when cfg_we&cfg_ready
- clear  in  1  request zeroing of sample history

## Operation
- States: CLEAR, IDLE, MAC.
- rst: state←CLEAR, clr_cnt←0, wr_ptr←0, out_valid←0, out_data←0, acc←0; coef[(TAPS-1)/2]←2^SHIFT, all others←0 (identity with (TAPS-1)/2 delay). History not reset directly; CLEAR zeroes it.
- CLEAR: one history entry zeroed per cycle, clr_cnt 0..TAPS-1, then IDLE. in_ready=cfg_ready=0.
- IDLE: in_ready=~clear, cfg_ready=1. Priority: clear > sample. clear → CLEAR (sample not accepted). Sample accept → history[wr_ptr]←in_data, newest←wr_ptr, wr_ptr←wr_ptr+1 mod TAPS, k←0, acc←0, → MAC.
- MAC: k=0..TAPS-1, one per cycle: acc ← acc + history[(newest−k) mod TAPS] × coef[k]. After k=TAPS-1: out_data←(final sum)[SHIFT+DW-1:SHIFT], out_valid←1, → IDLE. in_ready=cfg_ready=0; clear ignored (requester holds it).
- cfg write: effective only if cfg_addr<TAPS, else dropped. cfg_we with cfg_ready=0 dropped, no queuing. Simultaneous cfg write and sample accept in IDLE: both taken; the MAC run uses the new coefficient.
- Arithmetic: product DW+CW signed, sign-extended to ACCW; acc wraps mod 2^ACCW. Output is pure truncation (floor), no rounding or saturation; bits above slice discarded (wrap).
- out_valid is 1 for exactly one cycle per accepted sample.

## Timing
- After rst deasserts: CLEAR occupies TAPS cycles; in_ready first 1 in cycle TAPS.
- Sample accepted at edge ending cycle 0 → MAC cycles 1..TAPS → out_valid=1 in cycle TAPS+1, which is also IDLE (in_ready=1). Latency TAPS+1, max throughput 1 sample / (TAPS+1) cycles.
- rst mid-MAC: run aborted, no out_valid, re-enter CLEAR next cycle.
- clear in IDLE: TAPS cycles of CLEAR; wr_ptr and coefficients unchanged.
- in_valid deassert never required; in_data must hold while in_valid & ~in_ready.

## Test plan
- Reset: pulse rst, hold in_valid=1 → in_ready=0 cycles 0..14, 1 from cycle 15; out_valid=0, out_data=0 throughout.
- Identity default: samples 100,0,0,… → outputs 0×7, then 100, then 0; each out_valid exactly 16 cycles after its accept.
- ISOP load: write 54038,−157159,477137,−1038076,1504341,−868335,−3125632,14901461, mirrored, to taps 0..14; impulse 64 then zeros → outputs 0,−2,3,−8,11,−7,−24,113,−24,−7,11,−8,3,−2,0.
- Config gating: cfg_we during MAC to tap 7 → cfg_ready=0, write dropped, next identity output unchanged; cfg_addr=15 in IDLE → no effect.
- Simultaneous: in IDLE, cfg write coef[0]=2^23 with sample 20 in same cycle → that output = 20 (plus tap-7 term).
- Clear: history of constant 50, assert clear in IDLE → 15 CLEAR cycles, then impulse 0s → all outputs 0; clear during MAC ignored until IDLE.

Source files
------------

// File: rtl/isop_mac_scheduler.sv
// Serial-MAC ISOP FIR: one shared multiplier, TAPS-deep history, writable coefficient bank; latency TAPS+1 cycles.
// Backpressure: in_ready/cfg_ready only in IDLE, so at most one sample per TAPS+1 cycles; clear waits for IDLE.
module isop_mac_scheduler #(
    parameter int TAPS  = 15,
    parameter int DW    = 8,
    parameter int CW    = 26,
    parameter int ACCW  = 40,
    parameter int SHIFT = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_ready,
    input  logic          clear
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2
    } state_t;

    localparam logic [3:0]    LAST  = 4'(TAPS - 1);
    localparam logic [4:0]    NTAPS = 5'(TAPS);
    localparam logic [CW-1:0] UNITY = {{(CW-1){1'b0}}, 1'b1} << SHIFT;

    state_t               state_q, state_d;
    logic [3:0]           clr_cnt_q, clr_cnt_d;
    logic [3:0]           wr_ptr_q, wr_ptr_d;
    logic [3:0]           newest_q, newest_d;
    logic [3:0]           k_q, k_d;
    logic [ACCW-1:0]      acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic [CW-1:0]        coef_q [TAPS];
    logic [CW-1:0]        coef_d [TAPS];
    logic [DW-1:0]        hist_q [TAPS];
    logic [DW-1:0]        hist_d [TAPS];

    logic [3:0]              rd_idx;
    logic signed [DW+CW-1:0] prod;
    logic [ACCW-1:0]         prod_ext;

    // Tap k reads the sample k positions older than the newest, modulo TAPS.
    always_comb begin
        rd_idx   = newest_q - k_q + ((newest_q < k_q) ? 4'(TAPS) : 4'd0);
        prod     = $signed(hist_q[rd_idx]) * $signed(coef_q[k_q]);
        prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        newest_d    = newest_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        coef_d      = coef_q;
        hist_d      = hist_q;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                hist_d[clr_cnt_q] = '0;
                if (clr_cnt_q == LAST) begin
                    clr_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            ST_IDLE: begin
                cfg_ready = 1'b1;
                in_ready  = ~clear;
                if (clear) begin
                    clr_cnt_d = 4'd0;
                    state_d   = ST_CLEAR;
                end else if (in_valid) begin
                    hist_d[wr_ptr_q] = in_data;
                    newest_d         = wr_ptr_q;
                    wr_ptr_d         = (wr_ptr_q == LAST) ? 4'd0 : wr_ptr_q + 4'd1;
                    k_d              = 4'd0;
                    acc_d            = '0;
                    state_d          = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_ext;
                if (k_q == LAST) begin
                    out_data_d  = acc_d[SHIFT+DW-1:SHIFT];
                    out_valid_d = 1'b1;
                    k_d         = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // A write accepted alongside a sample lands before the MAC run reads it.
        if (cfg_we && cfg_ready && ({1'b0, cfg_addr} < NTAPS)) begin
            coef_d[cfg_addr] = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= 4'd0;
            wr_ptr_q    <= 4'd0;
            newest_q    <= 4'd0;
            k_q         <= 4'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= (i == (TAPS - 1) / 2) ? UNITY : '0;
            end
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            coef_q      <= coef_d;
        end
    end

    // History has no reset; the CLEAR sweep zeroes it after every rst.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_isop_mac_scheduler.sv
// Bench for isop_mac_scheduler: directed scenarios plus randomized traffic against a shift-register FIR model.
module tb_isop_mac_scheduler;

    localparam int TAPS  = 15;
    localparam int SHIFT = 23;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [25:0] cfg_data = 26'd0;
    logic        cfg_ready;
    logic        clear = 1'b0;

    int checks = 0;
    int errors = 0;

    longint hist_m [TAPS];
    longint coef_m [TAPS];

    isop_mac_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .clear    (clear)
    );

    always #5 clk = ~clk;

    // Reference: hist_m[k] is the sample accepted k samples ago; output is the floored, scaled dot product.
    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            hist_m[i] = 0;
            coef_m[i] = (i == (TAPS - 1) / 2) ? (64'sd1 <<< SHIFT) : 0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) hist_m[i] = 0;
    endtask

    task automatic model_push(input logic [7:0] x);
        logic signed [7:0] sx;
        sx = x;
        for (int i = TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = longint'(sx);
    endtask

    task automatic model_cfg(input logic [3:0] a, input logic [25:0] d);
        logic signed [25:0] sd;
        sd = d;
        if (int'(a) < TAPS) coef_m[a] = longint'(sd);
    endtask

    function automatic logic [7:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += hist_m[k] * coef_m[k];
        return 8'(s >>> SHIFT);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mid_action: 0 none, 1 cfg write to tap 7 three cycles into MAC, 2 raise and hold clear during MAC.
    task automatic do_sample(input logic [7:0] x, input bit with_cfg, input logic [3:0] ca,
                             input logic [25:0] cd, input int mid_action,
                             output logic [7:0] y, output int lat, output bit ov_after,
                             output bit rdy_at_out, output bit mid_rdy, output bit tmo);
        int w;
        w = 0; tmo = 1'b0; mid_rdy = 1'b0; y = 8'd0; ov_after = 1'b0; rdy_at_out = 1'b0; lat = 0;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_valid = 1'b1;
        in_data  = x;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
        end
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        model_push(x);
        if (with_cfg) model_cfg(ca, cd);
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (lat == 3 && mid_action == 1) begin
                cfg_we = 1'b1; cfg_addr = 4'd7; cfg_data = 26'd0;
                mid_rdy = cfg_ready;
            end
            if (lat == 3 && mid_action == 2) clear = 1'b1;
            step();
            cfg_we = 1'b0;
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        y = out_data;
        rdy_at_out = in_ready;
        step();
        ov_after = out_valid;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [25:0] d, output bit tmo);
        int w;
        w = 0; tmo = 1'b0;
        while (!cfg_ready && w < 200) begin
            step();
            w++;
        end
        if (!cfg_ready) begin
            tmo = 1'b1;
            return;
        end
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
        model_cfg(a, d);
    endtask

    task automatic set_identity(output bit tmo);
        bit t;
        tmo = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            cfg_write(4'(i), (i == 7) ? (26'd1 << SHIFT) : 26'd0, t);
            tmo |= t;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            checks++;
            if (in_ready !== (c == 15)) begin
                errors++;
                $display("FAIL reset_in_ready cycle %0d: got %b expected %b", c, in_ready, (c == 15));
            end
            checks++;
            if (out_valid !== 1'b0 || out_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got valid %b data %0d expected 0/0", c, out_valid, out_data);
            end
            if (c == 15) in_valid = 1'b0;
            else step();
        end
        model_reset();
    endtask

    task automatic test_identity();
        logic [7:0] exp_t [9];
        logic [7:0] y;
        int lat;
        bit ova, rdo, mrdy, tmo;
        exp_t = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0};
        for (int i = 0; i < 9; i++) begin
            do_sample((i == 0) ? 8'd100 : 8'd0, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL identity_timeout sample %0d", i);
            end
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL identity_latency sample %0d: got %0d expected 16", i, lat);
            end
            checks++;
            if (y !== exp_t[i]) begin
                errors++;
                $display("FAIL identity_data sample %0d: got %0d expected %0d", i, $signed(y), $signed(exp_t[i]));
            end
            checks++;
            if (ova !== 1'b0) begin
                errors++;
                $display("FAIL identity_pulse sample %0d: out_valid %b one cycle later, expected 0", i, ova);
            end
        end
    endtask

    task automatic do_clear(output int n);
        int w;
        w = 0;
        while (!cfg_ready && w < 200) begin
            step();
            w++;
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (!cfg_ready && n < 100) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_in_ready: got %b expected 0 during CLEAR", in_ready);
            end
            step();
            n++;
        end
        model_clear();
    endtask

    task automatic test_isop();
        int isop [8];
        int exp_t [15];
        int n;
        logic [7:0] y, e;
        int lat;
        bit ova, rdo, mrdy, tmo;
        isop  = '{54038, -157159, 477137, -1038076, 1504341, -868335, -3125632, 14901461};
        exp_t = '{0, -2, 3, -8, 11, -7, -24, 113, -24, -7, 11, -8, 3, -2, 0};
        do_clear(n);
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL isop_clear_len: got %0d expected 15", n);
        end
        for (int i = 0; i < TAPS; i++) begin
            cfg_write(4'(i), 26'((i < 8) ? isop[i] : isop[14 - i]), tmo);
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL isop_cfg_timeout tap %0d", i);
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            do_sample((i == 0) ? 8'd64 : 8'd0, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            e = 8'(exp_t[i]);
            checks++;
            if (tmo || y !== e) begin
                errors++;
                $display("FAIL isop_data output %0d: got %0d expected %0d (timeout %b)", i, $signed(y), exp_t[i], tmo);
            end
        end
    endtask

    task automatic test_cfg_gating();
        logic [7:0] y, e;
        int lat;
        bit ova, rdo, mrdy, tmo;
        set_identity(tmo);
        do_sample(8'd37, 1'b0, 4'd0, 26'd0, 1, y, lat, ova, rdo, mrdy, tmo);
        checks++;
        if (tmo || mrdy !== 1'b0) begin
            errors++;
            $display("FAIL gating_cfg_ready_mac: got %b expected 0 (timeout %b)", mrdy, tmo);
        end
        cfg_write(4'd15, 26'h1FFFFFF, tmo);
        for (int i = 0; i < 9; i++) begin
            do_sample(8'($urandom), 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            e = model_out();
            checks++;
            if (tmo || y !== e) begin
                errors++;
                $display("FAIL gating_data sample %0d: got %0d expected %0d (timeout %b)", i, $signed(y), $signed(e), tmo);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] y, e;
        int lat;
        bit ova, rdo, mrdy, tmo;
        do_sample(8'd20, 1'b1, 4'd0, 26'd1 << SHIFT, 0, y, lat, ova, rdo, mrdy, tmo);
        e = 8'(20 + hist_m[7]);
        checks++;
        if (tmo || y !== e) begin
            errors++;
            $display("FAIL simultaneous_data: got %0d expected %0d (timeout %b)", $signed(y), $signed(e), tmo);
        end
    endtask

    task automatic test_reset_mid_mac();
        int w, n;
        bit saw_ov, tmo;
        logic [7:0] y, e;
        int lat;
        bit ova, rdo, mrdy;
        w = 0;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        in_valid = 1'b1; in_data = 8'd77;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0; saw_ov = 1'b0;
        while (!in_ready && n < 100) begin
            saw_ov |= out_valid;
            step();
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL midreset_clear_len: got %0d expected 15", n);
        end
        checks++;
        if (saw_ov !== 1'b0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL midreset_no_output: got valid_seen %b data %0d expected 0/0", saw_ov, out_data);
        end
        model_reset();
        for (int i = 0; i < 9; i++) begin
            do_sample(8'($urandom), 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            e = model_out();
            checks++;
            if (tmo || y !== e) begin
                errors++;
                $display("FAIL midreset_data sample %0d: got %0d expected %0d (timeout %b)", i, $signed(y), $signed(e), tmo);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] y, e;
        int lat, n;
        bit ova, rdo, mrdy, tmo;
        for (int i = 0; i < TAPS; i++) begin
            do_sample(8'd50, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
        end
        e = model_out();
        checks++;
        if (tmo || y !== e) begin
            errors++;
            $display("FAIL clear_fill: got %0d expected %0d (timeout %b)", $signed(y), $signed(e), tmo);
        end
        do_clear(n);
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL clear_idle_len: got %0d expected 15", n);
        end
        for (int i = 0; i < 8; i++) begin
            do_sample(8'd0, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            checks++;
            if (tmo || y !== 8'd0) begin
                errors++;
                $display("FAIL clear_zero sample %0d: got %0d expected 0 (timeout %b)", i, $signed(y), tmo);
            end
        end
        for (int i = 0; i < 8; i++) begin
            do_sample(8'd50, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
        end
        do_sample(8'd50, 1'b0, 4'd0, 26'd0, 2, y, lat, ova, rdo, mrdy, tmo);
        e = model_out();
        checks++;
        if (tmo || lat !== 16 || y !== e) begin
            errors++;
            $display("FAIL clear_in_mac_output: got lat %0d data %0d expected lat 16 data %0d", lat, $signed(y), $signed(e));
        end
        checks++;
        if (rdo !== 1'b0) begin
            errors++;
            $display("FAIL clear_held_in_ready: got %b expected 0", rdo);
        end
        clear = 1'b0;
        n = 0;
        while (!cfg_ready && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL clear_after_mac_len: got %0d expected 15", n);
        end
        model_clear();
        for (int i = 0; i < 8; i++) begin
            do_sample(8'd0, 1'b0, 4'd0, 26'd0, 0, y, lat, ova, rdo, mrdy, tmo);
            checks++;
            if (tmo || y !== 8'd0) begin
                errors++;
                $display("FAIL clear_mac_zero sample %0d: got %0d expected 0 (timeout %b)", i, $signed(y), tmo);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] y, e;
        int lat;
        bit ova, rdo, mrdy, tmo, sim;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 3) == 0) cfg_write(4'($urandom_range(0, 15)), 26'($urandom), tmo);
            sim = ($urandom_range(0, 3) == 0);
            do_sample(8'($urandom), sim, 4'($urandom_range(0, 15)), 26'($urandom), 0,
                      y, lat, ova, rdo, mrdy, tmo);
            e = model_out();
            checks++;
            if (tmo || lat !== 16 || y !== e) begin
                errors++;
                $display("FAIL random_data iter %0d: got lat %0d data %0d expected lat 16 data %0d", i, lat, $signed(y), $signed(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_isop();
        test_cfg_gating();
        test_simultaneous();
        test_reset_mid_mac();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
